alu_operand_stage: RTL
======================

Name: alu_operand_stage

Overview:
Parametrised successor to the single-operand ALU source select. It sits between the ID and EX stages of the pipelined RV32 core. It selects both ALU operands (A: reg/PC/zero; B: reg/imm/const 4) and applies EX/MEM and MEM/WB forwarding to rs1/rs2. It detects load-use hazards and registers the result as the ID/EX operand pipeline register, with valid, stall and flush control.

Parameters:
XLEN, 32, datapath width of operands, immediates, PC and forwarded data
REG_AW, 5, register address width; register address 0 is hardwired zero and never forwarded

Ports:
clk_i  in  1  core clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
id_valid_i  in  1  ID stage holds a valid instruction
id_rs1_i  in  REG_AW  rs1 address
id_rs2_i  in  REG_AW  rs2 address
id_rs1_data_i  in  XLEN  register-file rs1 read data
id_rs2_data_i  in  XLEN  register-file rs2 read data
id_imm_i  in  XLEN  immediate from imm generator
id_pc_i  in  XLEN  instruction PC
id_src_a_i  in  2  operand A select: 0=rs1, 1=PC, 2=zero, 3=reserved (treated as zero)
id_src_b_i  in  2  operand B select: 0=rs2, 1=imm, 2=constant 4, 3=reserved (treated as zero)
id_store_i  in  1  instruction is a store; rs2 is needed as store data
ex_load_i  in  1  instruction currently in EX is a load
ex_rd_i  in  REG_AW  rd of the instruction in EX
exmem_wr_i  in  1  EX/MEM writes a register
exmem_rd_i  in  REG_AW  EX/MEM destination
exmem_data_i  in  XLEN  EX/MEM result
memwb_wr_i  in  1  MEM/WB writes a register
memwb_rd_i  in  REG_AW  MEM/WB destination
memwb_data_i  in  XLEN  MEM/WB write-back data
stall_i  in  1  downstream stall; hold the register contents
flush_i  in  1  branch/trap flush; kill the contents
hazard_o  out  1  combinational load-use stall request to IF/ID
ex_valid_o  out  1  registered operand set is valid
ex_op_a_o  out  XLEN  registered ALU operand A
ex_op_b_o  out  XLEN  registered ALU operand B
ex_store_data_o  out  XLEN  registered forwarded rs2 (store data)

Behaviour:
- Reset: while rst_i is high, all outputs are 0 and all registers are cleared asynchronously. Release is synchronous to clk_i.
- Forwarding, per source register rs:
  - If rs != 0, exmem_wr_i is set and exmem_rd_i == rs, use exmem_data_i.
  - Else if rs != 0, memwb_wr_i is set and memwb_rd_i == rs, use memwb_data_i.
  - Else use the register-file data.
  - EX/MEM has priority when both stages match.
- Operand mux: A and B select as listed above. Store data is always the forwarded rs2, independent of id_src_b_i.
- Use detection:
  - rs1 is used when id_src_a_i == 0.
  - rs2 is used when id_src_b_i == 0 or id_store_i is set.
- hazard_o (combinational) = id_valid_i & ex_load_i & ex_rd_i != 0 & ((rs1 used & ex_rd_i == id_rs1_i) | (rs2 used & ex_rd_i == id_rs2_i)).
- Register update on each clock edge, in priority order:
  1. flush_i: ex_valid_o <= 0; data registers may hold stale values.
  2. stall_i: all registers hold.
  3. hazard_o: bubble inserted; ex_valid_o <= 0.
  4. Otherwise: ex_valid_o <= id_valid_i and the operands are captured.
- Latency: one cycle from ID to EX outputs.
- Simultaneous flush_i and stall_i: flush wins.
- hazard_o with stall_i: hold; hazard_o stays asserted.
- Arithmetic: constant 4 is zero-extended to XLEN. No arithmetic is performed on the operands.

Decomposition:
- Package alu_operand_pkg holds:
  - enum src_a_e {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO}, 2 bits
  - enum src_b_e {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR}, 2 bits
  - constant REG_ZERO = 0
- One sub-module, fwd_select, is instantiated twice (rs1, rs2): a combinational priority forwarding mux returning the forwarded data.

Test Plan:
1. Reset: assert rst_i mid-cycle with ex_valid_o=1 -> all outputs 0 immediately. After release, first valid ID yields ex_valid_o=1 one cycle later.
2. Forward priority: rs1=5, exmem_rd=5 data 0xAAAA0000, memwb_rd=5 data 0x5555, src_a=0 -> ex_op_a_o=0xAAAA0000. With exmem_wr=0 -> 0x5555. With rs1=0 -> register-file data 0 and no forwarding.
3. Operand B modes: imm=0xFFFFFFF0, src_b=1 -> op_b=0xFFFFFFF0; src_b=2 -> 4; src_a=1, pc=0x100 -> op_a=0x100.
4. Load-use: ex_load=1, ex_rd=7, id_rs2=7, id_store=1, src_b=1 -> hazard_o=1 and next ex_valid_o=0. Same case with ex_rd=0 -> no hazard.
5. Stall/flush: stall_i=1 for 3 cycles -> outputs frozen. stall_i=1 and flush_i=1 together -> ex_valid_o=0 next cycle.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// Shared operand-select encodings and constants for the ID/EX operand stage.
package alu_operand_pkg;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } src_a_e;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } src_b_e;

  localparam int unsigned REG_ZERO   = 0;
  localparam int unsigned CONST_FOUR = 4;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux for one source register: EX/MEM beats MEM/WB beats register file.
module fwd_select
  import alu_operand_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [XLEN-1:0]   rf_data_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  output logic [XLEN-1:0]   data_o
);

  logic rs_nonzero;
  logic exmem_hit;
  logic memwb_hit;

  // x0 is hardwired zero, so it must never pick up a forwarded value.
  assign rs_nonzero = (rs_i != REG_AW'(REG_ZERO));
  assign exmem_hit  = rs_nonzero & exmem_wr_i & (exmem_rd_i == rs_i);
  assign memwb_hit  = rs_nonzero & memwb_wr_i & (memwb_rd_i == rs_i);

  always_comb begin
    data_o = rf_data_i;
    if (exmem_hit) begin
      data_o = exmem_data_i;
    end else if (memwb_hit) begin
      data_o = memwb_data_i;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: forwards rs1/rs2, selects ALU operands A/B, detects load-use
// hazards and registers the operand set with valid, stall and flush control.
module alu_operand_stage
  import alu_operand_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [1:0]        id_src_a_i,
  input  logic [1:0]        id_src_b_i,
  input  logic              id_store_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              exmem_wr_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]   exmem_data_i,
  input  logic              memwb_wr_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]   memwb_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              hazard_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_op_a_o,
  output logic [XLEN-1:0]   ex_op_b_o,
  output logic [XLEN-1:0]   ex_store_data_o
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            rs1_used;
  logic            rs2_used;
  logic            ex_rd_nonzero;

  logic            valid_d, valid_q;
  logic [XLEN-1:0] op_a_d, op_a_q;
  logic [XLEN-1:0] op_b_d, op_b_q;
  logic [XLEN-1:0] store_data_d, store_data_q;

  fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs1 (
    .rs_i         (id_rs1_i),
    .rf_data_i    (id_rs1_data_i),
    .exmem_wr_i   (exmem_wr_i),
    .exmem_rd_i   (exmem_rd_i),
    .exmem_data_i (exmem_data_i),
    .memwb_wr_i   (memwb_wr_i),
    .memwb_rd_i   (memwb_rd_i),
    .memwb_data_i (memwb_data_i),
    .data_o       (rs1_fwd)
  );

  fwd_select #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_fwd_rs2 (
    .rs_i         (id_rs2_i),
    .rf_data_i    (id_rs2_data_i),
    .exmem_wr_i   (exmem_wr_i),
    .exmem_rd_i   (exmem_rd_i),
    .exmem_data_i (exmem_data_i),
    .memwb_wr_i   (memwb_wr_i),
    .memwb_rd_i   (memwb_rd_i),
    .memwb_data_i (memwb_data_i),
    .data_o       (rs2_fwd)
  );

  always_comb begin
    op_a = '0;
    case (id_src_a_i)
      2'(SRC_A_RS1): op_a = rs1_fwd;
      2'(SRC_A_PC):  op_a = id_pc_i;
      default:       op_a = '0;
    endcase
  end

  always_comb begin
    op_b = '0;
    case (id_src_b_i)
      2'(SRC_B_RS2):  op_b = rs2_fwd;
      2'(SRC_B_IMM):  op_b = id_imm_i;
      2'(SRC_B_FOUR): op_b = XLEN'(CONST_FOUR);
      default:        op_b = '0;
    endcase
  end

  assign rs1_used      = (id_src_a_i == 2'(SRC_A_RS1));
  assign rs2_used      = (id_src_b_i == 2'(SRC_B_RS2)) | id_store_i;
  assign ex_rd_nonzero = (ex_rd_i != REG_AW'(REG_ZERO));

  // Gated by reset so every output reads zero while the stage is held in reset.
  assign hazard_o = ~rst_i & id_valid_i & ex_load_i & ex_rd_nonzero &
                    ((rs1_used & (ex_rd_i == id_rs1_i)) |
                     (rs2_used & (ex_rd_i == id_rs2_i)));

  always_comb begin
    valid_d      = valid_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    store_data_d = store_data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (stall_i) begin
      valid_d = valid_q;
    end else if (hazard_o) begin
      valid_d = 1'b0;
    end else begin
      valid_d      = id_valid_i;
      op_a_d       = op_a;
      op_b_d       = op_b;
      store_data_d = rs2_fwd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      store_data_q <= '0;
    end else begin
      valid_q      <= valid_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      store_data_q <= store_data_d;
    end
  end

  assign ex_valid_o      = valid_q;
  assign ex_op_a_o       = op_a_q;
  assign ex_op_b_o       = op_b_q;
  assign ex_store_data_o = store_data_q;

endmodule
